optoml_skid_buffer: RTL and testbench

OPTOML_SKID_BUFFER -- requirements
Module: optoml_skid_buffer

---
 rtl/optoml_stream_pkg.sv | 22 ++
 rtl/optoml_skid_buffer_if.sv | 23 ++
 rtl/optoml_skid_buffer.sv | 70 +++++++
 tb/tb_optoml_skid_buffer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/optoml_stream_pkg.sv
// Shared stream definitions: skid-buffer state encoding, default widths and
// the state-to-occupancy mapping.
package optoml_stream_pkg;

  localparam int STREAM_DATA_WIDTH = 32;
  localparam int STREAM_OCC_WIDTH  = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  function automatic logic [STREAM_OCC_WIDTH-1:0] occupancy_of(input skid_state_t s);
    case (s)
      BUSY:    occupancy_of = 2'd1;
      FULL:    occupancy_of = 2'd2;
      default: occupancy_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/optoml_skid_buffer_if.sv
// Upstream and downstream handshake of the skid buffer, bundled in one interface.
// A beat transfers on a rising edge where valid && ready; valid and data must stay
// put until that edge, and ready may never depend combinationally on valid.
interface optoml_skid_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/optoml_skid_buffer.sv
// Two-entry skid buffer: main drives out_data, skid catches the beat accepted
// while downstream stalls. Every output comes straight from a flop.
module optoml_skid_buffer
  import optoml_stream_pkg::*;
#(
  parameter int DATA_WIDTH = STREAM_DATA_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset,
  optoml_skid_buffer_if.slave         bus,
  output logic [STREAM_OCC_WIDTH-1:0] occupancy,
  output skid_state_t                 state
);

  skid_state_t                 state_q;
  skid_state_t                 state_next;
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic [STREAM_OCC_WIDTH-1:0] occ_q;
  logic [DATA_WIDTH-1:0]       main_q;
  logic [DATA_WIDTH-1:0]       skid_q;
  logic                        accept;
  logic                        pop;

  assign accept = bus.in_valid && in_ready_q;
  assign pop    = out_valid_q && bus.out_ready;

  always_comb begin
    state_next = state_q;
    case (state_q)
      EMPTY: if (accept) state_next = BUSY;
      BUSY: begin
        if (accept && !pop)      state_next = FULL;
        else if (pop && !accept) state_next = EMPTY;
      end
      FULL:    if (pop) state_next = BUSY;
      default: state_next = EMPTY;
    endcase
  end

  // Status flops are loaded from the next state so they line up with state_q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      occ_q       <= '0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_next;
      in_ready_q  <= (state_next != FULL);
      out_valid_q <= (state_next != EMPTY);
      occ_q       <= occupancy_of(state_next);
      if (accept && (state_q == EMPTY || (state_q == BUSY && pop)))
        main_q <= bus.in_data;
      else if (state_q == FULL && pop)
        main_q <= skid_q;
      if (accept && state_q == BUSY && !pop)
        skid_q <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign occupancy     = occ_q;
  assign state         = state_q;

endmodule

// File: tb/tb_optoml_skid_buffer.sv
// Directed and random bench for optoml_skid_buffer against a queue model.
module tb_optoml_skid_buffer;
  import optoml_stream_pkg::*;

  localparam int W = 32;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  optoml_skid_buffer_if #(.DATA_WIDTH(W)) bus ();
  logic [1:0]  occupancy;
  skid_state_t state;

  optoml_skid_buffer #(.DATA_WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .occupancy (occupancy),
    .state     (state)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  bit           fresh;
  bit           hold_pending;
  logic [W-1:0] hold_data;
  int           pop_count;
  bit           last_accept;
  bit           taken;
  bit           pattern[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // drivers: inputs set just after a falling edge, handshakes judged before the rising edge
  task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    #1;
    if (fresh) begin
      check("ready_before_first_edge", bus.in_ready, 0);
      fresh = 1'b0;
    end else begin
      check("in_ready", bus.in_ready, exp_q.size() < 2);
    end
    check("out_valid", bus.out_valid, exp_q.size() != 0);
    check("occupancy", occupancy, exp_q.size());
    if (hold_pending) check("hold_stable", bus.out_data, hold_data);
    hold_pending = bus.out_valid && !bus.out_ready;
    hold_data    = bus.out_data;
    if (bus.out_valid && bus.out_ready) begin
      pop_count++;
      check("pop_has_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("pop_data", bus.out_data, exp_q.pop_front());
    end
    last_accept = bus.in_valid && bus.in_ready;
    if (last_accept) exp_q.push_back(bus.in_data);
    @(negedge clock);
  endtask

  task automatic release_reset();
    reset = 1'b0;
    exp_q.delete();
    fresh        = 1'b1;
    hold_pending = 1'b0;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_state", state, EMPTY);
    check("rst_main_clear", bus.out_data, 0);
    release_reset();
  endtask

  initial begin
    do_reset();

    // first beat after reset release
    step(1'b1, 32'hA5A5_0001, 1'b1);
    check("first_no_accept_in_reset_cycle", last_accept, 0);
    step(1'b1, 32'hA5A5_0001, 1'b1);
    check("first_accept", last_accept, 1);
    check("first_out_valid", bus.out_valid, 1);
    check("first_out_data", bus.out_data, 32'hA5A5_0001);
    step(1'b0, '0, 1'b1);

    // back-to-back stream at full rate
    pop_count = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 32'h10 + i, 1'b1);
    step(1'b0, '0, 1'b1);
    check("stream_beats", pop_count, 16);

    // fill both entries under backpressure
    step(1'b1, 32'h20, 1'b0);
    step(1'b1, 32'h21, 1'b0);
    check("full_occupancy", occupancy, 2);
    check("full_in_ready", bus.in_ready, 0);
    check("full_state", state, FULL);
    check("full_main", bus.out_data, 32'h20);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // 0xDEAD waits while FULL, enters only once in_ready is back
    step(1'b1, 32'h30, 1'b0);
    step(1'b1, 32'h31, 1'b0);
    taken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(!taken, 32'hDEAD, pattern[i]);
      if (i == 0) check("dead_blocked_while_full", last_accept, 0);
      if (last_accept) taken = 1'b1;
    end
    check("dead_taken", taken, 1);
    check("dead_drained", exp_q.size(), 0);

    // asynchronous reset while FULL
    step(1'b1, 32'h40, 1'b0);
    step(1'b1, 32'h41, 1'b0);
    check("pre_reset_occupancy", occupancy, 2);
    #2 reset = 1'b1;
    #1;
    check("async_out_valid", bus.out_valid, 0);
    check("async_occupancy", occupancy, 0);
    check("async_in_ready", bus.in_ready, 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clock);
    release_reset();
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // random traffic
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    check("drain_empty", exp_q.size(), 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
